// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter
//   Shares one registered ALU (single-cycle latency) between NUM_REQ
//   requesters. Round-robin grant and at most one operation in flight.
//   Each operation walks IDLE -> ISSUE -> WAIT -> RESP -> IDLE. The result
//   returns to the requester that issued it, tagged with its index.
//
// Handshake semantics (valid/ready):
//   A transfer happens on a rising clock edge where valid and ready are both
//   1. A producer holds its payload stable while valid=1 and ready=0. Ready
//   never depends on anything except the consumer's own state and the
//   producer's valid.
//
// Ports:
//   i_clk, i_rst        clock (rising edge), async active-high reset
//   i_req_valid         per-requester request valid
//   i_req_data_a/_b     packed operands, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_req_inst          packed opcodes, requester k at [k*INST_WIDTH +: INST_WIDTH]
//   o_req_ready         one-hot accept, asserted only in IDLE
//   o_alu_data_a/_b     captured operands to the ALU (held in all states)
//   o_alu_inst          captured opcode to the ALU (held in all states)
//   o_alu_valid         one-cycle issue strobe to the ALU
//   i_alu_data          ALU result
//   i_alu_overflow      ALU overflow flag
//   i_alu_valid         ALU result valid (only looked at in WAIT)
//   o_rsp_valid         response valid, held until i_rsp_ready
//   o_rsp_id            index of the requester being answered
//   o_rsp_data          result
//   o_rsp_overflow      overflow flag
//   o_rsp_error         watchdog timeout flag (0 unless ALU_ARB_TIMEOUT_EN)
//   i_rsp_ready         response consumer ready
//   o_dbg_state         current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP)
//
// Optional build macro ALU_ARB_TIMEOUT_EN: adds a WAIT watchdog. If the ALU
// has not answered after TIMEOUT_CYC cycles, the operation completes with
// o_rsp_error=1 and zero data. A later i_alu_valid is ignored.

module alu_rr_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int INST_WIDTH  = 4,
   parameter int ID_WIDTH    = 2,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic [NUM_REQ-1:0]             i_req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_data_a,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_data_b,
   input  logic [NUM_REQ*INST_WIDTH-1:0]  i_req_inst,
   output logic [NUM_REQ-1:0]             o_req_ready,
   output logic [DATA_WIDTH-1:0]          o_alu_data_a,
   output logic [DATA_WIDTH-1:0]          o_alu_data_b,
   output logic [INST_WIDTH-1:0]          o_alu_inst,
   output logic                           o_alu_valid,
   input  logic [DATA_WIDTH-1:0]          i_alu_data,
   input  logic                           i_alu_overflow,
   input  logic                           i_alu_valid,
   output logic                           o_rsp_valid,
   output logic [ID_WIDTH-1:0]            o_rsp_id,
   output logic [DATA_WIDTH-1:0]          o_rsp_data,
   output logic                           o_rsp_overflow,
   output logic                           o_rsp_error,
   input  logic                           i_rsp_ready,
   output logic [1:0]                     o_dbg_state
);

   generate
      if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << ID_WIDTH) < NUM_REQ || TIMEOUT_CYC < 1) begin : g_bad_cfg
         $error("alu_rr_arbiter: illegal parameter combination");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ID_WIDTH-1:0] ptr_q;
   logic [ID_WIDTH-1:0] grant_id;
   logic [ID_WIDTH-1:0] next_ptr;
   logic                grant_found;
   logic                accept;
   logic                timeout;

   // Cyclic search starting at the pointer: the first valid requester wins.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!grant_found && i_req_valid[(int'(ptr_q) + i) % NUM_REQ]) begin
            grant_found = 1'b1;
            grant_id    = ID_WIDTH'((int'(ptr_q) + i) % NUM_REQ);
         end
      end
   end

   assign next_ptr = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + ID_WIDTH'(1);
   assign accept   = (state_q == S_IDLE) && grant_found;

   // Ready is masked by reset so that every output reads 0 while reset is held.
   assign o_req_ready = (accept && !i_rst) ? (NUM_REQ'(1) << grant_id) : '0;

   assign o_alu_valid = (state_q == S_ISSUE);
   assign o_rsp_valid = (state_q == S_RESP);
   assign o_dbg_state = state_q;

`ifdef ALU_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] wait_cnt_q;
   logic             rsp_error_q;

   // The counter holds 0 on the first WAIT cycle, so it fires after
   // TIMEOUT_CYC full WAIT cycles with no answer from the ALU.
   assign timeout = (state_q == S_WAIT) && !i_alu_valid &&
                    (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wait_cnt_q  <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         if (state_q == S_ISSUE) begin
            wait_cnt_q <= '0;
         end else if (state_q == S_WAIT) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
         end
         if (state_q == S_WAIT && i_alu_valid) begin
            rsp_error_q <= 1'b0;
         end else if (timeout) begin
            rsp_error_q <= 1'b1;
         end
      end
   end

   assign o_rsp_error = rsp_error_q;
`else
   assign timeout     = 1'b0;
   assign o_rsp_error = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (grant_found) state_d = S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  if (i_alu_valid || timeout) state_d = S_RESP;
         S_RESP:  if (i_rsp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q        <= S_IDLE;
         ptr_q          <= '0;
         o_alu_data_a   <= '0;
         o_alu_data_b   <= '0;
         o_alu_inst     <= '0;
         o_rsp_id       <= '0;
         o_rsp_data     <= '0;
         o_rsp_overflow <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            o_alu_data_a <= i_req_data_a[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
            o_alu_data_b <= i_req_data_b[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
            o_alu_inst   <= i_req_inst[int'(grant_id)*INST_WIDTH +: INST_WIDTH];
            o_rsp_id     <= grant_id;
            ptr_q        <= next_ptr;
         end
         // ALU answers are taken only in WAIT; anything else is stray.
         if (state_q == S_WAIT && i_alu_valid) begin
            o_rsp_data     <= i_alu_data;
            o_rsp_overflow <= i_alu_overflow;
         end else if (timeout) begin
            o_rsp_data     <= '0;
            o_rsp_overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
module tb_alu_rr_arbiter;
   localparam int N  = 4;
   localparam int DW = 32;
   localparam int IW = 4;
   localparam int IDW = 2;
   localparam int TO = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- stimulus and DUT wiring ----------------
   logic [N-1:0]    req_valid = '0;
   logic [DW-1:0]   a_arr [N];
   logic [DW-1:0]   b_arr [N];
   logic [IW-1:0]   i_arr [N];
   logic [N*DW-1:0] req_a_p, req_b_p;
   logic [N*IW-1:0] req_i_p;
   logic            rsp_ready = 1'b1;
   logic            alu_mute = 1'b0;
   logic            late_pulse = 1'b0;

   logic [N-1:0]    req_ready;
   logic [DW-1:0]   alu_a, alu_b;
   logic [IW-1:0]   alu_inst;
   logic            alu_valid_o;
   logic [DW-1:0]   alu_data;
   logic            alu_ovf;
   logic            alu_valid_i;
   logic            rsp_valid;
   logic [IDW-1:0]  rsp_id;
   logic [DW-1:0]   rsp_data;
   logic            rsp_ovf, rsp_err;
   logic [1:0]      dbg_state;

   always_comb begin
      req_a_p = '0;
      req_b_p = '0;
      req_i_p = '0;
      for (int k = 0; k < N; k++) begin
         req_a_p[k*DW +: DW] = a_arr[k];
         req_b_p[k*DW +: DW] = b_arr[k];
         req_i_p[k*IW +: IW] = i_arr[k];
      end
   end

   alu_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .INST_WIDTH(IW), .ID_WIDTH(IDW), .TIMEOUT_CYC(TO)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid), .i_req_data_a(req_a_p), .i_req_data_b(req_b_p), .i_req_inst(req_i_p),
      .o_req_ready(req_ready),
      .o_alu_data_a(alu_a), .o_alu_data_b(alu_b), .o_alu_inst(alu_inst), .o_alu_valid(alu_valid_o),
      .i_alu_data(alu_data), .i_alu_overflow(alu_ovf), .i_alu_valid(alu_valid_i),
      .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_data(rsp_data),
      .o_rsp_overflow(rsp_ovf), .o_rsp_error(rsp_err), .i_rsp_ready(rsp_ready),
      .o_dbg_state(dbg_state)
   );

   // Reference ALU function: {overflow, result}.
   function automatic logic [DW:0] alu_f(input logic [IW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW-1:0] r;
      logic ov;
      r  = a;
      ov = 1'b0;
      case (op)
         4'd0: begin r = a + b; ov = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]); end
         4'd1: begin r = a - b; ov = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]); end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd13: r = ~a;
         default: r = a;
      endcase
      return {ov, r};
   endfunction

   // Registered ALU environment model, one-cycle latency.
   logic          alu_v_r;
   logic [DW-1:0] alu_d_r;
   logic          alu_o_r;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_v_r <= 1'b0;
         alu_d_r <= '0;
         alu_o_r <= 1'b0;
      end else begin
         alu_v_r <= alu_valid_o & ~alu_mute;
         {alu_o_r, alu_d_r} <= alu_f(alu_inst, alu_a, alu_b);
      end
   end
   assign alu_data    = alu_d_r;
   assign alu_ovf     = alu_o_r;
   assign alu_valid_i = alu_v_r | late_pulse;

   // ---------------- scoreboard / reference model ----------------
   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Transaction-level model: round-robin pointer, one outstanding op, and
   // its age in cycles since acceptance.
   int            ptr = 0;
   bit            busy = 0;
   int            age = 0;
   int            rsp_age = 3;
   int            cyc = 0;
   int            last_acc = 0;
   logic [DW-1:0] ea = '0, eb = '0;
   logic [IW-1:0] ei = '0;
   int            e_id = 0;
   logic [DW-1:0] exp_q [$];
   logic          e_ovf = 1'b0, e_err = 1'b0;
   int            grant_q [$];
   int            gap_q [$];
   logic [N-1:0]  last_gmask = '0;
   bit            hold_granted = 0;
   int            n_rsp = 0;
   int            last_id = 0;
   logic [DW-1:0] last_data = '0;
   logic          last_ovf = 1'b0, last_err = 1'b0;

   task automatic model_reset();
      ptr = 0; busy = 0; age = 0;
      ea = '0; eb = '0; ei = '0;
      exp_q.delete();
   endtask

   // One clock cycle: compare at the falling edge, advance the model across
   // the rising edge, then release the caller 1 time unit after it.
   task automatic step();
      logic [N-1:0] er;
      logic [DW:0]  res;
      bit           rsp_exp;
      @(negedge clk);
      er = '0;
      if (!busy) begin
         for (int i = 0; i < N; i++) begin
            int k;
            k = (ptr + i) % N;
            if (er == '0 && req_valid[k]) er[k] = 1'b1;
         end
      end
      check("req_ready", req_ready, er);
      check("alu_valid", alu_valid_o, busy && age == 1);
      check("alu_a", alu_a, ea);
      check("alu_b", alu_b, eb);
      check("alu_inst", alu_inst, ei);
      rsp_exp = busy && age >= rsp_age;
      check("rsp_valid", rsp_valid, rsp_exp);
      if (rsp_exp) begin
         check("rsp_id", rsp_id, e_id);
         check("rsp_data", rsp_data, exp_q[0]);
         check("rsp_ovf", rsp_ovf, e_ovf);
         check("rsp_err", rsp_err, e_err);
      end
      last_gmask = er;
      if (er != '0) begin
         for (int k = 0; k < N; k++) if (er[k]) e_id = k;
         ea = a_arr[e_id]; eb = b_arr[e_id]; ei = i_arr[e_id];
         res = alu_f(ei, ea, eb);
         exp_q.delete();
         if (alu_mute) begin
            exp_q.push_back('0); e_ovf = 1'b0; e_err = 1'b1; rsp_age = TO + 2;
         end else begin
            exp_q.push_back(res[DW-1:0]); e_ovf = res[DW]; e_err = 1'b0; rsp_age = 3;
         end
         ptr = (e_id + 1) % N;
         busy = 1; age = 1;
         grant_q.push_back(e_id);
         gap_q.push_back(cyc - last_acc);
         last_acc = cyc;
      end else if (busy) begin
         if (age >= rsp_age && rsp_ready) begin
            busy = 0;
            n_rsp++;
            last_id = e_id; last_data = exp_q[0]; last_ovf = e_ovf; last_err = e_err;
            // Observed values, captured for the directed constant checks.
            last_data = rsp_data; last_ovf = rsp_ovf; last_err = rsp_err;
            last_id = int'(rsp_id);
         end else begin
            age++;
         end
      end
      cyc++;
      @(posedge clk);
      #1;
      if (!hold_granted) req_valid = req_valid & ~last_gmask;
   endtask

   task automatic set_req(input int k, input logic [IW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
      a_arr[k] = a; b_arr[k] = b; i_arr[k] = op;
      req_valid[k] = 1'b1;
   endtask

   task automatic wait_rsp(input string tag, input int budget);
      int n0;
      int c;
      n0 = n_rsp;
      c = 0;
      while (n_rsp == n0 && c < budget) begin step(); c++; end
      check({tag, "_budget"}, n_rsp != n0, 1'b1);
   endtask

   task automatic drain();
      int c;
      c = 0;
      req_valid = '0;
      rsp_ready = 1'b1;
      while (busy && c < 60) begin step(); c++; end
      check("drain_budget", busy, 1'b0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"}, req_ready, '0);
      check({tag, "_alu_valid"}, alu_valid_o, 1'b0);
      check({tag, "_alu_a"}, alu_a, '0);
      check({tag, "_alu_b"}, alu_b, '0);
      check({tag, "_alu_inst"}, alu_inst, '0);
      check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
      check({tag, "_rsp_id"}, rsp_id, '0);
      check({tag, "_rsp_data"}, rsp_data, '0);
      check({tag, "_rsp_ovf"}, rsp_ovf, 1'b0);
      check({tag, "_rsp_err"}, rsp_err, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      int c;
      for (int k = 0; k < N; k++) begin a_arr[k] = '0; b_arr[k] = '0; i_arr[k] = '0; end

      // Reset state, with requests pending to show ready stays low.
      rst = 1'b1;
      req_valid = '1;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      req_valid = '0;
      rst = 1'b0;
      model_reset();

      // Round-robin: all four held valid for five operations.
      grant_q.delete(); gap_q.delete();
      hold_granted = 1;
      for (int k = 0; k < N; k++) set_req(k, IW'($urandom_range(0, 4)), $urandom, $urandom);
      c = 0;
      while (grant_q.size() < 5 && c < 40) begin
         step();
         c++;
         for (int k = 0; k < N; k++)
            if (last_gmask[k]) begin a_arr[k] = $urandom; b_arr[k] = $urandom; end
      end
      hold_granted = 0;
      check("rr_count", grant_q.size(), 5);
      if (grant_q.size() == 5) begin
         check("rr_g0", grant_q[0], 0);
         check("rr_g1", grant_q[1], 1);
         check("rr_g2", grant_q[2], 2);
         check("rr_g3", grant_q[3], 3);
         check("rr_g4", grant_q[4], 0);
         for (int i = 1; i < 5; i++) check("rr_gap", gap_q[i], 4);
      end
      drain();

      // Single add from requester 1.
      set_req(1, 4'd0, 32'd5, 32'd7);
      wait_rsp("add", 20);
      check("add_id", last_id, 1);
      check("add_data", last_data, 32'd12);
      check("add_ovf", last_ovf, 1'b0);

      // Signed overflow passes through.
      set_req(0, 4'd0, 32'h7FFF_FFFF, 32'd1);
      wait_rsp("ovf", 20);
      check("ovf_id", last_id, 0);
      check("ovf_data", last_data, 32'h8000_0000);
      check("ovf_flag", last_ovf, 1'b1);

      // Backpressure: response held 5 extra cycles while requester 1 waits.
      rsp_ready = 1'b0;
      set_req(3, 4'd4, $urandom, $urandom);
      step();
      set_req(1, 4'd1, $urandom, $urandom);
      c = 0;
      while (!(busy && age >= rsp_age) && c < 20) begin step(); c++; end
      check("bp_reach_resp", busy && age >= rsp_age, 1'b1);
      repeat (5) step();
      rsp_ready = 1'b1;
      c = grant_q.size();
      while (grant_q.size() == c && busy && c < 1000) step();
      c = 0;
      while (last_gmask == '0 && c < 10) begin step(); c++; end
      check("bp_prev_id", last_id, 3);
      check("bp_next_grant", grant_q[$], 1);
      drain();

      // Reset in WAIT aborts the operation.
      set_req(0, 4'd2, $urandom, $urandom);
      c = 0;
      while (!(busy && age == 2) && c < 20) begin step(); c++; end
      check("rst_reach_wait", busy && age == 2, 1'b1);
      set_req(2, 4'd13, 32'd0, $urandom);
      rst = 1'b1;
      #1;
      check_all_zero("midop_rst");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      c = n_rsp;
      wait_rsp("after_rst", 20);
      check("after_rst_id", last_id, 2);
      check("after_rst_data", last_data, 32'hFFFF_FFFF);

      // Randomized traffic: arrivals, withdrawals, backpressure, stray ALU valids.
      for (int t = 0; t < 400; t++) begin
         for (int k = 0; k < N; k++) begin
            if (!req_valid[k]) begin
               if ($urandom_range(0, 2) == 0) begin
                  logic [IW-1:0] op;
                  op = ($urandom_range(0, 3) == 0) ? 4'd13 : IW'($urandom_range(0, 15));
                  set_req(k, op, $urandom, $urandom);
               end
            end else if ($urandom_range(0, 9) == 0) begin
               req_valid[k] = 1'b0;
            end
         end
         rsp_ready  = ($urandom_range(0, 9) < 7);
         late_pulse = (!busy || age != 2) && ($urandom_range(0, 5) == 0);
         step();
      end
      late_pulse = 1'b0;
      drain();

`ifdef ALU_ARB_TIMEOUT_EN
      // Silent ALU: watchdog completes the op with an error; late valid ignored.
      alu_mute  = 1'b1;
      rsp_ready = 1'b0;
      set_req(1, 4'd0, 32'd3, 32'd4);
      c = 0;
      while (!(busy && age >= rsp_age) && c < 40) begin step(); c++; end
      check("to_reach_resp", busy && age == TO + 2, 1'b1);
      alu_mute   = 1'b0;
      late_pulse = 1'b1;
      step();
      late_pulse = 1'b0;
      rsp_ready  = 1'b1;
      wait_rsp("to", 10);
      check("to_err", last_err, 1'b1);
      check("to_data", last_data, '0);
      check("to_id", last_id, 1);
      drain();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one registered ALU (1-cycle latency, 4-bit opcode, 32-bit operands, valid-in/valid-out) between NUM_REQ requesters.
- Round-robin arbitration with at most one operation in flight.
- Sequences the ALU handshake and returns each result to the requester that issued it.
- Sits between requester logic and the ALU instance; it is the ALU's only driver.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_WIDTH, 32: operand/result width.
- INST_WIDTH, 4: opcode width.
- ID_WIDTH, 2: width of requester index; must satisfy 2^ID_WIDTH >= NUM_REQ.
- TIMEOUT_CYC, 16: watchdog limit in WAIT; used only with the optional feature.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_req_valid  in  NUM_REQ  per-requester request valid.
- i_req_data_a  in  NUM_REQ*DATA_WIDTH  packed operand A; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_req_data_b  in  NUM_REQ*DATA_WIDTH  packed operand B, same packing.
- i_req_inst  in  NUM_REQ*INST_WIDTH  packed opcode, same packing.
- o_req_ready  out  NUM_REQ  one-hot accept.
- o_alu_data_a  out  DATA_WIDTH  to ALU.
- o_alu_data_b  out  DATA_WIDTH  to ALU.
- o_alu_inst  out  INST_WIDTH  to ALU.
- o_alu_valid  out  1  to ALU.
- i_alu_data  in  DATA_WIDTH  from ALU.
- i_alu_overflow  in  1  from ALU.
- i_alu_valid  in  1  from ALU.
- o_rsp_valid  out  1  response valid.
- o_rsp_id  out  ID_WIDTH  index of the requester being answered.
- o_rsp_data  out  DATA_WIDTH  result.
- o_rsp_overflow  out  1  overflow flag.
- o_rsp_error  out  1  timeout flag; constant 0 without the optional feature.
- i_rsp_ready  in  1  response consumer ready.

Behaviour:
- Reset (async, i_rst=1):
  - State = IDLE.
  - All registered outputs = 0.
  - Round-robin pointer = 0, so requester 0 has highest priority first.
  - Operand/result capture registers = 0.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Grant = first k with i_req_valid[k]=1, searching cyclically from the pointer.
  - o_req_ready[grant]=1, combinational, only in IDLE; all other ready bits = 0.
  - On the accepting edge: capture that requester's A, B and inst plus the grant id; set pointer = grant+1 (mod NUM_REQ); go to ISSUE.
  - No valid requests: stay in IDLE, ready = 0.
- ISSUE:
  - o_alu_valid=1 for exactly one cycle, with the captured operands and opcode on o_alu_*.
  - Next state WAIT.
  - o_alu_data_a/b/inst hold their captured values in all states; o_alu_valid is 1 only in ISSUE.
- WAIT:
  - On i_alu_valid=1, capture i_alu_data and i_alu_overflow into the response registers and go to RESP.
  - Nominal ALU: i_alu_valid arrives on the first WAIT cycle.
- RESP:
  - o_rsp_valid=1 with o_rsp_id/data/overflow/error stable until i_rsp_ready=1.
  - On the handshake edge: o_rsp_valid drops and state returns to IDLE.
  - Minimum 4 cycles per operation.
- Boundary conditions:
  - i_alu_valid outside WAIT is ignored.
  - A request withdrawn before it is granted is simply never granted; no fairness credit is kept.
  - Requests arriving while not in IDLE wait; no ready is asserted outside IDLE.
  - Reset asserted in any state aborts the operation and returns to IDLE with no response issued.
  - An opcode outside 0..14 is forwarded unchanged; the arbiter performs no opcode checks.
  - Requesters must hold i_req_* stable while i_req_valid=1 and ready=0.

Optional Feature:
- Macro ALU_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WAIT and increments each cycle in WAIT.
  - If it reaches TIMEOUT_CYC without i_alu_valid: go to RESP with o_rsp_error=1, o_rsp_data=0, o_rsp_overflow=0, o_rsp_id = granted id.
  - A late i_alu_valid for that operation is ignored.
- When undefined: no counter is built, WAIT waits indefinitely, and o_rsp_error is tied to 0.

Test Plan:
- Single add: req1 valid, A=5, B=7, inst=0 -> ready[1] pulses one cycle; o_alu_valid one cycle later; o_rsp_valid=1 with id=1, data=12, overflow=0 three cycles after accept (i_rsp_ready=1).
- Overflow passthrough: req0 A=0x7FFFFFFF, B=1, inst=0 -> rsp data=0x80000000, overflow=1, id=0.
- Round-robin: all 4 requests held valid for 5 operations, i_rsp_ready=1 -> grant/rsp id order 0,1,2,3,0; each operation occupies 4 cycles.
- Backpressure: i_rsp_ready=0 for 5 cycles in RESP -> rsp fields stable, o_req_ready=0 throughout; on ready=1, return to IDLE and the next grant follows.
- Reset mid-op: assert i_rst in WAIT -> all outputs 0 immediately; after release, req2 inst=13, A=0 -> rsp data=0xFFFFFFFF, id=2.
- Timeout (ALU_ARB_TIMEOUT_EN, TIMEOUT_CYC=16): ALU model never returns valid -> after 16 WAIT cycles o_rsp_valid=1, error=1, data=0; a late i_alu_valid is ignored.
